// File: rtl/signed_acc_pkg.sv
// signed_acc_pkg: shared sizing and clamp-limit helpers for the signed accumulate/dump path
// Contents: clog2, acc_width (product width plus growth for NACC terms), sat_max/sat_min of an output width.
package signed_acc_pkg;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int acc_width(input int pwidth, input int nacc);
    return pwidth + clog2(nacc);
  endfunction
  function automatic logic signed [63:0] sat_max(input int ow);
    return (64'sd1 <<< (ow - 1)) - 64'sd1;
  endfunction
  function automatic logic signed [63:0] sat_min(input int ow);
    return -(64'sd1 <<< (ow - 1));
  endfunction
endpackage

// File: rtl/signed_accumulate_round_saturate.sv
// round_saturate: round-half-up by SHIFT LSBs, then clamp a signed value into OWIDTH bits
// Ports: i_data (IWIDTH, signed), o_data (OWIDTH, signed result), o_sat (result was clamped).
module round_saturate
  import signed_acc_pkg::*;
#(
  parameter int IWIDTH = 35,
  parameter int SHIFT  = 8,
  parameter int OWIDTH = 24
) (
  input  logic [IWIDTH-1:0] i_data,
  output logic [OWIDTH-1:0] o_data,
  output logic              o_sat
);
  // one guard bit so adding the half-LSB can never wrap
  localparam int RW = IWIDTH + 1;
  localparam logic signed [RW-1:0] MAX = RW'(sat_max(OWIDTH));
  localparam logic signed [RW-1:0] MIN = RW'(sat_min(OWIDTH));
  logic signed [RW-1:0] ext, rnd, shf;
  logic hi, lo;
  assign ext = {i_data[IWIDTH-1], i_data};
  if (SHIFT > 0) begin : g_rnd
    localparam logic signed [RW-1:0] HALF = RW'(1) <<< (SHIFT - 1);
    assign rnd = ext + HALF;
  end else begin : g_nrnd
    assign rnd = ext;
  end
  always_comb begin
    shf    = rnd >>> SHIFT;
    hi     = shf > MAX;
    lo     = shf < MIN;
    o_sat  = hi || lo;
    o_data = hi ? MAX[OWIDTH-1:0] : lo ? MIN[OWIDTH-1:0] : shf[OWIDTH-1:0];
  end
endmodule

// File: rtl/signed_accumulate_dump.sv
// signed_accumulate_dump: integrate NACC signed products, then emit one rounded, saturated result per frame
// Ports: i_clk, i_reset (async, active-high), i_clear (sync frame restart), i_valid/o_ready/i_prod (product in),
//        o_valid/i_ready/o_data (result out). Define SIGNED_ACC_SAT_FLAG_EN to add o_sat (result was clamped).
module signed_accumulate_dump
  import signed_acc_pkg::*;
#(
  parameter int PWIDTH = 33,
  parameter int NACC   = 16,
  parameter int SHIFT  = 8,
  parameter int OWIDTH = 24
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [PWIDTH-1:0] i_prod,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [OWIDTH-1:0] o_data
`ifdef SIGNED_ACC_SAT_FLAG_EN
  ,
  output logic              o_sat
`endif
);
  localparam int AW = acc_width(PWIDTH, NACC);
  localparam int CW = NACC > 1 ? clog2(NACC) : 1;
  localparam logic [CW-1:0] LAST = CW'(NACC - 1);
  logic signed [AW-1:0] acc_q, acc_d, base_acc, sum;
  logic [CW-1:0] cnt_q, cnt_d, base_cnt;
  logic valid_q, valid_d, accept, dump;
  logic [OWIDTH-1:0] data_q, data_d, rs_data;
`ifdef SIGNED_ACC_SAT_FLAG_EN
  logic rs_sat, sat_q;
  assign o_sat = sat_q;
`else
  logic unused_sat;
`endif
  // i_clear restarts the frame before this cycle's sample is folded in
  always_comb begin
    o_ready  = !(cnt_q == LAST && valid_q && !i_ready);
    accept   = i_valid && o_ready;
    base_acc = i_clear ? '0 : acc_q;
    base_cnt = i_clear ? '0 : cnt_q;
    sum      = base_acc + AW'(signed'(i_prod));
    dump     = accept && base_cnt == LAST;
    acc_d    = dump ? '0 : accept ? sum : base_acc;
    cnt_d    = dump ? '0 : accept ? base_cnt + CW'(1) : base_cnt;
    valid_d  = dump || (valid_q && !i_ready);
    data_d   = dump ? rs_data : data_q;
  end
  round_saturate #(.IWIDTH(AW), .SHIFT(SHIFT), .OWIDTH(OWIDTH)) u_rs (
    .i_data(sum),
    .o_data(rs_data),
`ifdef SIGNED_ACC_SAT_FLAG_EN
    .o_sat (rs_sat)
`else
    .o_sat (unused_sat)
`endif
  );
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
`ifdef SIGNED_ACC_SAT_FLAG_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
`ifdef SIGNED_ACC_SAT_FLAG_EN
      sat_q   <= dump ? rs_sat : sat_q;
`endif
    end
  end
  assign o_valid = valid_q;
  assign o_data  = data_q;
endmodule

// File: tb/tb_signed_accumulate_dump.sv
// tb_signed_accumulate_dump: directed checks of accumulate, round, saturate, backpressure, clear and async reset
module tb_signed_accumulate_dump;
  logic i_clk = 1'b0, i_reset = 1'b1, i_clear = 1'b0, i_valid = 1'b0, i_ready = 1'b1;
  logic [32:0] i_prod = '0;
  logic o_ready, o_valid;
  logic [15:0] o_data;
  int errors = 0, checks = 0;
`ifdef SIGNED_ACC_SAT_FLAG_EN
  logic o_sat;
`endif
  signed_accumulate_dump #(.PWIDTH(33), .NACC(4), .SHIFT(4), .OWIDTH(16)) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_clear(i_clear),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_prod (i_prod),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_data (o_data)
`ifdef SIGNED_ACC_SAT_FLAG_EN
    ,
    .o_sat  (o_sat)
`endif
  );
  always #5 i_clk = ~i_clk;
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask
  task automatic send(input int p);
    i_valid = 1'b1;
    i_prod  = 33'(p);
    step();
    i_valid = 1'b0;
  endtask
  task automatic frame(input int a, input int b, input int c, input int d);
    send(a);
    send(b);
    send(c);
    send(d);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] res(input int v);
    return {15'b0, 1'b1, 16'(v)};
  endfunction
  function automatic logic [31:0] out_now();
    return {15'b0, o_valid, o_data};
  endfunction
  initial begin
    #12;
    chk("reset_out", out_now(), 32'd0);
    chk("reset_ready", {31'b0, o_ready}, 32'd1);
    #1 i_reset = 1'b0;
    step();
    frame(16, 16, 16, 16);
    chk("basic_1", out_now(), res(4));
    send(16);
    chk("basic_pop", {31'b0, o_valid}, 32'd0);
    send(16);
    send(16);
    send(16);
    chk("basic_b2b", out_now(), res(4));
    frame(8, 0, 0, 0);
    chk("round_p8", out_now(), res(1));
    frame(-8, 0, 0, 0);
    chk("round_m8", out_now(), res(0));
    frame(-9, 0, 0, 0);
    chk("round_m9", out_now(), res(-1));
    frame(7, 0, 0, 0);
    chk("round_p7", out_now(), res(0));
    frame(1 << 30, 1 << 30, 1 << 30, 1 << 30);
    chk("sat_pos", out_now(), res(32767));
`ifdef SIGNED_ACC_SAT_FLAG_EN
    chk("sat_pos_flag", {31'b0, o_sat}, 32'd1);
`endif
    frame(-(1 << 30), -(1 << 30), -(1 << 30), -(1 << 30));
    chk("sat_neg", out_now(), res(-32768));
`ifdef SIGNED_ACC_SAT_FLAG_EN
    chk("sat_neg_flag", {31'b0, o_sat}, 32'd1);
`endif
    frame(16, 16, 16, 16);
    chk("sat_after", out_now(), res(4));
`ifdef SIGNED_ACC_SAT_FLAG_EN
    chk("sat_after_flag", {31'b0, o_sat}, 32'd0);
`endif
    i_ready = 1'b0;
    send(32);
    send(32);
    send(32);
    chk("bp_ready_low", {31'b0, o_ready}, 32'd0);
    chk("bp_held_a", out_now(), res(4));
    i_valid = 1'b1;
    i_prod  = 33'd32;
    step();
    chk("bp_held_b", out_now(), res(4));
    chk("bp_still_low", {31'b0, o_ready}, 32'd0);
    i_ready = 1'b1;
    #1;
    chk("bp_ready_comb", {31'b0, o_ready}, 32'd1);
    step();
    i_valid = 1'b0;
    chk("bp_new", out_now(), res(8));
    step();
    chk("bp_drain", {31'b0, o_valid}, 32'd0);
    send(100);
    send(100);
    i_clear = 1'b1;
    send(16);
    i_clear = 1'b0;
    send(16);
    send(16);
    send(16);
    chk("clear", out_now(), res(4));
    frame(16, 16, 16, 16);
    i_ready = 1'b0;
    send(16);
    send(16);
    chk("pre_reset", out_now(), res(4));
    #2 i_reset = 1'b1;
    #1;
    chk("async_reset", out_now(), 32'd0);
    #2 i_reset = 1'b0;
    i_ready = 1'b1;
    frame(16, 16, 16, 16);
    chk("post_reset", out_now(), res(4));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
